// File: rtl/bcd_clock_pkg.sv
// Shared BCD limits, time payload types and digit arithmetic helpers for the RTC.
package bcd_clock_pkg;

  localparam logic [7:0] BCD_MAX_MS  = 8'h59;
  localparam logic [7:0] BCD_MAX_H24 = 8'h23;
  localparam logic [7:0] BCD_H12     = 8'h12;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
  } bcd_hm_t;

  function automatic logic bcd_digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Increment a two-digit BCD value, wrapping to 00 after max.
  function automatic logic [7:0] bcd_inc_mod(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] h24_to_h12(input logic [7:0] h);
    if (h == 8'h00) return BCD_H12;
    if (h <= BCD_H12) return h;
    if (h[3:0] >= 4'd2) return {h[7:4] - 4'd1, h[3:0] - 4'd2};
    return {h[7:4] - 4'd2, h[3:0] + 4'd8};
  endfunction

  function automatic logic [7:0] h12_to_h24(input logic [7:0] h, input logic pm);
    if (h == BCD_H12) return pm ? BCD_H12 : 8'h00;
    if (!pm) return h;
    if (h[3:0] <= 4'd7) return {h[7:4] + 4'd1, h[3:0] + 4'd2};
    return {h[7:4] + 4'd2, h[3:0] - 4'd8};
  endfunction

  function automatic logic hour_ok(input logic [7:0] h, input logic m24);
    if (!bcd_digits_ok(h)) return 1'b0;
    if (m24) return h <= BCD_MAX_H24;
    return (h != 8'h00) && (h <= BCD_H12);
  endfunction

  function automatic logic min_sec_ok(input logic [7:0] v);
    return bcd_digits_ok(v) && (v <= BCD_MAX_MS);
  endfunction

  function automatic logic [7:0] entry_to_h24(input logic [7:0] h, input logic pm,
                                              input logic m24);
    return m24 ? h : h12_to_h24(h, pm);
  endfunction

endpackage

// File: rtl/bcd_clock_rtc_if.sv
// Control, preset and display bundle between the RTC and its host/display logic.
interface bcd_clock_rtc_if;
  logic       ena;
  logic       mode24;
  logic       load;
  logic [7:0] ld_hh;
  logic [7:0] ld_mm;
  logic [7:0] ld_ss;
  logic       ld_pm;
  logic       alarm_set;
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       al_pm;
  logic       alarm_en;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       tick;
  logic       alarm;
  logic       ld_err;

  modport master (
    output ena, mode24, load, ld_hh, ld_mm, ld_ss, ld_pm,
           alarm_set, al_hh, al_mm, al_pm, alarm_en,
    input  hh, mm, ss, pm, tick, alarm, ld_err
  );

  modport slave (
    input  ena, mode24, load, ld_hh, ld_mm, ld_ss, ld_pm,
           alarm_set, al_hh, al_mm, al_pm, alarm_en,
    output hh, mm, ss, pm, tick, alarm, ld_err
  );
endinterface

// File: rtl/bcd_clock_rtc_tick_gen.sv
// 1 Hz prescaler: counts enabled cycles and flags the wrap edge that advances time.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic clr,
  output logic adv
);
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign adv = ena && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (adv) cnt_d = '0;
    else if (ena) cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bcd_clock_rtc.sv
// BCD real-time clock: 24h internal time, 12/24h display, validated preset and hh:mm alarm.
module bcd_clock_rtc
  import bcd_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic           clk,
  input  logic           reset,
  bcd_clock_rtc_if.slave bus
);
  logic      adv;
  logic      ld_ok, al_ok;
  bcd_time_t time_q, time_d, ld_time, inc_time;
  bcd_hm_t   al_q, al_d, al_in;
  logic      tick_q, tick_d, alarm_q, alarm_d, ld_err_q, ld_err_d;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .ena   (bus.ena),
    .clr   (ld_ok),
    .adv   (adv)
  );

  // Validate presets and normalise them to 24-hour BCD.
  always_comb begin
    ld_ok = bus.load && hour_ok(bus.ld_hh, bus.mode24) &&
            min_sec_ok(bus.ld_mm) && min_sec_ok(bus.ld_ss);
    al_ok = bus.alarm_set && hour_ok(bus.al_hh, bus.mode24) && min_sec_ok(bus.al_mm);
    ld_time = '{hh: entry_to_h24(bus.ld_hh, bus.ld_pm, bus.mode24),
                mm: bus.ld_mm, ss: bus.ld_ss};
    al_in   = '{hh: entry_to_h24(bus.al_hh, bus.al_pm, bus.mode24), mm: bus.al_mm};
  end

  always_comb begin
    inc_time.ss = bcd_inc_mod(time_q.ss, BCD_MAX_MS);
    inc_time.mm = (time_q.ss == BCD_MAX_MS) ? bcd_inc_mod(time_q.mm, BCD_MAX_MS)
                                            : time_q.mm;
    inc_time.hh = ((time_q.ss == BCD_MAX_MS) && (time_q.mm == BCD_MAX_MS))
                  ? bcd_inc_mod(time_q.hh, BCD_MAX_H24) : time_q.hh;
  end

  // A valid load wins over a coincident advance; alarm only fires on counted seconds.
  always_comb begin
    time_d   = time_q;
    al_d     = al_q;
    tick_d   = 1'b0;
    alarm_d  = 1'b0;
    ld_err_d = (bus.load && !ld_ok) || (bus.alarm_set && !al_ok);
    if (ld_ok) begin
      time_d = ld_time;
    end else if (adv) begin
      time_d  = inc_time;
      tick_d  = 1'b1;
      alarm_d = bus.alarm_en && (inc_time == {al_q.hh, al_q.mm, 8'h00});
    end
    if (al_ok) al_d = al_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q   <= '0;
      al_q     <= '0;
      tick_q   <= 1'b0;
      alarm_q  <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      time_q   <= time_d;
      al_q     <= al_d;
      tick_q   <= tick_d;
      alarm_q  <= alarm_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bus.hh     = bus.mode24 ? time_q.hh : h24_to_h12(time_q.hh);
  assign bus.mm     = time_q.mm;
  assign bus.ss     = time_q.ss;
  assign bus.pm     = (time_q.hh >= BCD_H12);
  assign bus.tick   = tick_q;
  assign bus.alarm  = alarm_q;
  assign bus.ld_err = ld_err_q;
endmodule

// File: tb/tb_bcd_clock_rtc.sv
// Scoreboard bench for bcd_clock_rtc against a seconds-of-day reference model.
module tb_bcd_clock_rtc;
  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  bcd_clock_rtc_if bus ();

  bcd_clock_rtc #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         phase;
    logic [7:0] hh, mm, ss;
    logic       pm, tick, alarm, err;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   phase    = 0;
  int   m_tod, m_pre, m_al;

  function automatic bit dec_bcd(input logic [7:0] b, input int max, output int v);
    v = 10 * int'(b[7:4]) + int'(b[3:0]);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Decode an entry (per display mode) into seconds of day.
  function automatic bit dec_time(input logic [7:0] h, input logic [7:0] m,
                                  input logic [7:0] s, input logic pm, input logic m24,
                                  input bit chk_ss, output int t);
    int hv, mv, sv;
    bit okh, okm, oks;
    okh = dec_bcd(h, m24 ? 23 : 12, hv);
    if (!m24) begin
      okh = okh && (hv >= 1);
      hv  = (hv % 12) + (pm ? 12 : 0);
    end
    okm = dec_bcd(m, 59, mv);
    oks = dec_bcd(s, 59, sv);
    if (!chk_ss) begin
      oks = 1'b1;
      sv  = 0;
    end
    t = hv * 3600 + mv * 60 + sv;
    return okh && okm && oks;
  endfunction

  // Advance the model one clock edge with the current inputs and queue the expectation.
  task automatic cyc();
    exp_t e;
    int   lt, at, h;
    bit   lok, aok, adv;
    e.tick = 1'b0; e.alarm = 1'b0; e.err = 1'b0;
    if (reset) begin
      m_tod = 0; m_pre = 0; m_al = 0;
    end else begin
      lok = dec_time(bus.ld_hh, bus.ld_mm, bus.ld_ss, bus.ld_pm, bus.mode24, 1'b1, lt);
      aok = dec_time(bus.al_hh, bus.al_mm, 8'h00, bus.al_pm, bus.mode24, 1'b0, at);
      lok = lok && bus.load;
      aok = aok && bus.alarm_set;
      e.err = (bus.load && !lok) || (bus.alarm_set && !aok);
      adv = bus.ena && (m_pre == int'(TICK_DIV) - 1);
      if (lok) begin
        m_tod = lt;
        m_pre = 0;
      end else if (bus.ena) begin
        m_pre = adv ? 0 : m_pre + 1;
        if (adv) begin
          m_tod   = (m_tod + 1) % 86400;
          e.tick  = 1'b1;
          e.alarm = bus.alarm_en && (m_tod == m_al * 60);
        end
      end
      if (aok) m_al = at / 60;
    end
    h       = m_tod / 3600;
    e.hh    = bus.mode24 ? to_bcd(h) : to_bcd((h % 12 == 0) ? 12 : h % 12);
    e.mm    = to_bcd((m_tod / 60) % 60);
    e.ss    = to_bcd(m_tod % 60);
    e.pm    = (h >= 12);
    e.phase = phase;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic pm);
    bus.ld_hh = h; bus.ld_mm = m; bus.ld_ss = s; bus.ld_pm = pm;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic set_ld(input int h24, input int m, input int s);
    bus.ld_hh = bus.mode24 ? to_bcd(h24) : to_bcd((h24 % 12 == 0) ? 12 : h24 % 12);
    bus.ld_mm = to_bcd(m);
    bus.ld_ss = to_bcd(s);
    bus.ld_pm = bus.mode24 ? 1'($urandom_range(0, 1)) : (h24 >= 12);
  endtask

  task automatic set_al(input int h24, input int m);
    bus.al_hh = bus.mode24 ? to_bcd(h24) : to_bcd((h24 % 12 == 0) ? 12 : h24 % 12);
    bus.al_mm = to_bcd(m);
    bus.al_pm = (h24 >= 12);
  endtask

  // Monitor: compare every registered/displayed output one step after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_checks++;
      if (bus.hh !== e.hh || bus.mm !== e.mm || bus.ss !== e.ss || bus.pm !== e.pm ||
          bus.tick !== e.tick || bus.alarm !== e.alarm || bus.ld_err !== e.err) begin
        $display("FAIL phase%0d t=%0t: got %h:%h:%h pm=%b tick=%b alarm=%b ld_err=%b, required %h:%h:%h pm=%b tick=%b alarm=%b ld_err=%b",
                 e.phase, $time, bus.hh, bus.mm, bus.ss, bus.pm, bus.tick, bus.alarm,
                 bus.ld_err, e.hh, e.mm, e.ss, e.pm, e.tick, e.alarm, e.err);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    int r, h, m, s, nm;
    reset = 1'b1;
    bus.ena = 1'b0; bus.mode24 = 1'b0; bus.load = 1'b0; bus.alarm_set = 1'b0;
    bus.ld_hh = '0; bus.ld_mm = '0; bus.ld_ss = '0; bus.ld_pm = 1'b0;
    bus.al_hh = '0; bus.al_mm = '0; bus.al_pm = 1'b0; bus.alarm_en = 1'b0;
    @(negedge clk);

    phase = 1;
    repeat (2) cyc();
    reset = 1'b0;
    bus.ena = 1'b1;
    repeat (12) cyc();
    bus.mode24 = 1'b1;
    repeat (4) cyc();

    phase = 2;
    bus.mode24 = 1'b0;
    do_load(8'h11, 8'h59, 8'h59, 1'b0);
    repeat (5) cyc();
    bus.mode24 = 1'b1;
    repeat (2) cyc();

    phase = 3;
    do_load(8'h23, 8'h59, 8'h59, 1'b0);
    repeat (5) cyc();
    bus.mode24 = 1'b0;
    repeat (2) cyc();

    phase = 4;
    do_load(8'h13, 8'h00, 8'h00, 1'b0);
    cyc();
    do_load(8'h05, 8'h5A, 8'h00, 1'b0);
    cyc();
    bus.mode24 = 1'b1;
    do_load(8'h24, 8'h00, 8'h00, 1'b0);
    cyc();

    phase = 5;
    bus.mode24 = 1'b0;
    bus.alarm_en = 1'b1;
    bus.al_hh = 8'h07; bus.al_mm = 8'h30; bus.al_pm = 1'b0;
    bus.alarm_set = 1'b1;
    cyc();
    bus.alarm_set = 1'b0;
    do_load(8'h07, 8'h29, 8'h59, 1'b0);
    repeat (6) cyc();
    bus.alarm_en = 1'b0;
    do_load(8'h07, 8'h29, 8'h59, 1'b0);
    repeat (6) cyc();

    phase = 6;
    bus.mode24 = 1'b1;
    for (int i = 0; i < 2 * int'(TICK_DIV) && m_pre != int'(TICK_DIV) - 1; i++) cyc();
    do_load(8'h10, 8'h00, 8'h00, 1'b0);
    repeat (6) cyc();
    bus.ena = 1'b0;
    repeat (10) cyc();
    bus.ena = 1'b1;
    repeat (5) cyc();

    phase = 7;
    bus.alarm_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.mode24 = ~bus.mode24;
      if ($urandom_range(0, 49) == 0) bus.alarm_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 6) begin
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(50, 59);
        set_ld(h, m, s);
        bus.load = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          nm = (h * 60 + m + 1) % 1440;
          set_al(nm / 60, nm % 60);
          bus.alarm_set = 1'b1;
        end
      end else if (r < 9) begin
        bus.ld_hh = 8'($urandom_range(0, 255));
        bus.ld_mm = 8'($urandom_range(0, 255));
        bus.ld_ss = 8'($urandom_range(0, 255));
        bus.ld_pm = 1'($urandom_range(0, 1));
        bus.load  = 1'b1;
      end else if (r < 11) begin
        bus.al_hh = 8'($urandom_range(0, 255));
        bus.al_mm = 8'($urandom_range(0, 255));
        bus.al_pm = 1'($urandom_range(0, 1));
        bus.alarm_set = 1'b1;
      end
      cyc();
      bus.load = 1'b0;
      bus.alarm_set = 1'b0;
    end

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_clock_rtc.md
Name: bcd_clock_rtc

Overview:
Parametrised successor to the team's 12-hour BCD clock. It is a free-running BCD real-time clock with:
- an internal 1 Hz prescaler driven from the system clock;
- a 12/24-hour display mode selectable at runtime;
- validated time preset;
- an hh:mm alarm with a one-cycle match pulse.

It sits between the board clock and the seven-segment/LED display path. Time is held internally in 24-hour BCD and converted for display.

Parameters:
TICK_DIV, 100_000_000, clk cycles per second advance (>=1). TICK_DIV=1 advances on every enabled cycle.
DIV_W, $clog2(TICK_DIV) (min 1), prescaler counter width (derived, not overridden).

Ports:
clk  in  1  system clock; all logic on posedge clk
reset  in  1  synchronous, active-high
ena  in  1  count enable; gates prescaler and time advance
mode24  in  1  1 = 24-hour display/entry, 0 = 12-hour
load  in  1  one-cycle strobe: preset time from ld_*
ld_hh, ld_mm, ld_ss  in  8 each  BCD preset, interpreted per mode24
ld_pm  in  1  PM flag for preset (ignored when mode24=1)
alarm_set  in  1  one-cycle strobe: store al_hh/al_mm/al_pm
al_hh, al_mm  in  8 each  BCD alarm time, interpreted per mode24
al_pm  in  1  alarm PM flag (ignored when mode24=1)
alarm_en  in  1  alarm match enable
hh, mm, ss  out  8 each  BCD display time
pm  out  1  1 when internal hour >= 12, in both modes
tick  out  1  registered pulse, high the cycle the new second appears
alarm  out  1  registered one-cycle match pulse
ld_err  out  1  registered one-cycle pulse: rejected load/alarm_set

Behaviour:
- Reset values:
  - ss=00, mm=00, internal hour h24=00 (display 12 in 12h mode, 00 in 24h mode), pm=0.
  - tick=0, alarm=0, ld_err=0, prescaler=0, alarm register=00:00.
- Prescaler:
  - When ena=1 it counts 0..TICK_DIV-1.
  - On the edge where count==TICK_DIV-1 and ena=1, it wraps to 0 and the time advances one second.
  - tick=1 for exactly the following cycle.
  - When ena=0, the prescaler and time hold and tick=0.
- Advance:
  - ss low digit 0-9, high digit 0-5.
  - Carry to mm at ss=59; same rule for mm.
  - Carry to h24 at mm=59&&ss=59.
  - h24 runs 00-23 in BCD (09->10, 19->20, 23->00).
  - Full wrap: 23:59:59 -> 00:00:00.
- Display conversion (combinational from h24 and mode24):
  - mode24=1: hh=h24.
  - mode24=0: h24 00->12, 01-12 unchanged, 13-23 -> 01-11.
  - mode24 toggling never alters stored time.
- pm:
  - Derived as h24>=12.
  - Rises 11:59:59->12:00:00, falls 23:59:59->00:00:00.
- Load validation:
  - Every digit must be <=9 and mm, ss must be <=59.
  - Hour must be 01-12 when mode24=0, or 00-23 when mode24=1.
  - 12h-to-24h conversion: 12AM->00, 12PM->12, 01-11PM -> +12 (BCD).
- load:
  - Valid: ss/mm/h24 updated on that edge and prescaler cleared to 0.
  - Invalid: state unchanged and ld_err=1 next cycle.
  - load beats a coincident second advance: the advance is discarded and tick stays 0.
- alarm_set:
  - Validated the same way, with the seconds check skipped.
  - Stores alarm as 24h BCD hh:mm; invalid -> ld_err.
  - load and alarm_set in the same cycle are both processed; ld_err=1 if either is invalid.
- alarm:
  - Goes to 1 for one cycle, coincident with tick, when the new time equals alarm_hh:alarm_mm:00 and alarm_en=1.
  - A time reached via load never fires alarm.
- reset overrides ena, load and alarm_set.

Decomposition:
- Package bcd_clock_pkg:
  - BCD limit constants: 8'h59, 8'h23, 8'h12.
  - Functions bcd_digits_ok, bcd_inc_mod (increment with max), h24_to_h12, h12_to_h24.
- Sub-module tick_gen (params TICK_DIV):
  - Inputs clk, reset, ena, clr.
  - Output adv: a combinational wrap condition.
- The top module instantiates tick_gen and holds all time, alarm and validation logic.

Test Plan:
1. TICK_DIV=4, reset then ena=1, mode24=0 -> hh=12 pm=0 at reset, tick every 4th cycle, ss 00->01->02. With mode24=1, hh=00.
2. mode24=0, load 11:59:59 ld_pm=0, one tick -> hh=12 mm=00 ss=00 pm=1. Switching mode24=1 shows hh=12.
3. mode24=1, load 23:59:59, one tick -> hh=00 mm=00 ss=00 pm=0. With mode24=0, hh=12.
4. mode24=0, ld_hh=8'h13 -> ld_err pulse, time unchanged. ld_mm=8'h5A -> ld_err. mode24=1, ld_hh=8'h24 -> ld_err.
5. alarm_set 07:30 AM (mode24=0), alarm_en=1, load 07:29:59 -> alarm high for exactly one cycle with tick at 07:30:00. Repeat with alarm_en=0 -> no pulse.
6. Load asserted on the prescaler wrap edge -> loaded value held, tick=0, next tick exactly TICK_DIV enabled cycles later. ena=0 for 10 cycles -> ss and prescaler frozen.
